// File: rtl/zapper_pkg.sv
// Shared definitions for the zapper light-gun front end: channel FSM
// encoding and the counter width helper.
package zapper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_F,
        ST_MEAS,
        ST_DONE
    } zap_state_t;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/zapper_channel.sv
// One light-gun channel: trigger/light synchronisers, trigger debounce,
// shot request handshake and per-frame light measurement.
module zapper_channel
    import zapper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int HIT_THRESH       = 64,
    parameter int FLASH_FRAMES     = 2,
    parameter int TRIG_ACTIVE_LOW  = 1,
    parameter int LIGHT_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger_in,
    input  logic light_in,
    input  logic frame_start,
    input  logic shot_ack,
    output logic shot_req,
    output logic result_valid,
    output logic result_hit,
    output logic busy
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int LIT_W = cnt_width(HIT_THRESH);
    localparam int FL_W  = cnt_width(FLASH_FRAMES);

    localparam logic             TRIG_INV  = (TRIG_ACTIVE_LOW != 0);
    localparam logic             LIGHT_INV = (LIGHT_ACTIVE_LOW != 0);
    // The counter has reached DEBOUNCE_CYCLES-1 on the edge where it would step past this value.
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [LIT_W-1:0] LIT_MAX   = LIT_W'(HIT_THRESH);
    localparam logic [FL_W-1:0]  FL_INIT   = FL_W'(FLASH_FRAMES);

    logic trig_p0, trig_p1;
    logic light_p0, light_p1;
    logic trig_act, light_act;

    logic            deb;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    zap_state_t       state, state_n;
    logic [LIT_W-1:0] lit_cnt, lit_n;
    logic [FL_W-1:0]  frames_left, fl_n;
    logic             hit_acc, acc_n;
    logic             vld_n, hit_n;

    // Two-flop synchronisers; reset to the idle (inactive) pin level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_p0  <= TRIG_INV;
            trig_p1  <= TRIG_INV;
            light_p0 <= LIGHT_INV;
            light_p1 <= LIGHT_INV;
        end else begin
            trig_p0  <= trigger_in;
            trig_p1  <= trig_p0;
            light_p0 <= light_in;
            light_p1 <= light_p0;
        end
    end

    assign trig_act  = trig_p1 ^ TRIG_INV;
    assign light_act = light_p1 ^ LIGHT_INV;

    // Debounce: accept a new trigger level once it has persisted; pulse on press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb    <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (trig_act != deb) begin
                if (db_cnt == DB_LAST) begin
                    deb    <= trig_act;
                    db_cnt <= '0;
                    press  <= trig_act;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Next-state and next-output logic of the shot sequence.
    always_comb begin
        state_n = state;
        lit_n   = lit_cnt;
        fl_n    = frames_left;
        acc_n   = hit_acc;
        vld_n   = 1'b0;
        hit_n   = result_hit;
        case (state)
            ST_IDLE: begin
                if (press) state_n = ST_REQ;
            end
            ST_REQ: begin
                // A frame_start coinciding with the ack is deliberately not used.
                if (shot_ack) state_n = ST_WAIT_F;
            end
            ST_WAIT_F: begin
                if (frame_start) begin
                    state_n = ST_MEAS;
                    lit_n   = '0;
                    fl_n    = FL_INIT;
                end
            end
            ST_MEAS: begin
                if (frame_start) begin
                    acc_n = hit_acc | (lit_cnt >= LIT_MAX);
                    lit_n = '0;
                    fl_n  = frames_left - FL_W'(1);
                    if (frames_left == FL_W'(1)) begin
                        state_n = ST_DONE;
                        vld_n   = 1'b1;
                        hit_n   = hit_acc | (lit_cnt >= LIT_MAX);
                        acc_n   = 1'b0;
                    end
                end else if (light_act && (lit_cnt != LIT_MAX)) begin
                    lit_n = lit_cnt + LIT_W'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            lit_cnt      <= '0;
            frames_left  <= '0;
            hit_acc      <= 1'b0;
            shot_req     <= 1'b0;
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            lit_cnt      <= lit_n;
            frames_left  <= fl_n;
            hit_acc      <= acc_n;
            shot_req     <= (state_n == ST_REQ);
            result_valid <= vld_n;
            result_hit   <= hit_n;
            busy         <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: rtl/zapper_multi_sampler.sv
// Multi-channel light-gun front end: NUM_CH independent zapper channels
// sharing the frame_start timing pulse.
module zapper_multi_sampler
    import zapper_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int HIT_THRESH       = 64,
    parameter int FLASH_FRAMES     = 2,
    parameter int TRIG_ACTIVE_LOW  = 1,
    parameter int LIGHT_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trigger_in,
    input  logic [NUM_CH-1:0] light_in,
    input  logic              frame_start,
    output logic [NUM_CH-1:0] shot_req,
    input  logic [NUM_CH-1:0] shot_ack,
    output logic [NUM_CH-1:0] result_valid,
    output logic [NUM_CH-1:0] result_hit,
    output logic [NUM_CH-1:0] busy
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        zapper_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HIT_THRESH      (HIT_THRESH),
            .FLASH_FRAMES    (FLASH_FRAMES),
            .TRIG_ACTIVE_LOW (TRIG_ACTIVE_LOW),
            .LIGHT_ACTIVE_LOW(LIGHT_ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .trigger_in  (trigger_in[g]),
            .light_in    (light_in[g]),
            .frame_start (frame_start),
            .shot_ack    (shot_ack[g]),
            .shot_req    (shot_req[g]),
            .result_valid(result_valid[g]),
            .result_hit  (result_hit[g]),
            .busy        (busy[g])
        );
    end

endmodule
